eth_frame_tx: RTL and testbench
===============================

# eth_frame_tx

Byte-stream Ethernet frame serializer that sits directly downstream of the header generator. On a start strobe it latches an `ethernet_header` and emits the following bytes on a valid/ready byte stream toward the MAC/PHY adapter:

- preamble and SFD;
- the 14 header bytes;
- payload bytes passed through from an upstream byte source;
- zero padding up to the minimum payload length;
- a CRC-32 FCS;
- an enforced inter-frame gap.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 1500: maximum payload bytes emitted per frame.
- `IFG_CYCLES`, default 12: idle cycles after the last FCS byte.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  single clock.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Frame control:
  - `start`  in  1  frame request; sampled only while `busy`=0.
  - `header`  in  `ethernet_header`  latched when `start` is accepted.
  - `busy`  out  1  high from the accepted `start` until the IFG ends.
- Payload input stream:
  - `s_data`  in  8  payload byte.
  - `s_valid`  in  1  payload byte valid.
  - `s_last`  in  1  final payload byte.
  - `s_ready`  out  1  payload byte accepted when `s_valid`&&`s_ready`.
- Frame output stream:
  - `m_data`  out  8  frame byte.
  - `m_valid`  out  1  frame byte valid.
  - `m_last`  out  1  high on the final FCS byte.
  - `m_ready`  in  1  downstream accepts the byte when `m_valid`&&`m_ready`.
- Status:
  - `trunc_err`  out  1  one-cycle pulse when a payload exceeding `MAX_PAYLOAD` is truncated.

## Operation
- Byte order:
  - Header arrays are already in network order; element [0] goes first.
  - Wire order is `mac_destination`[0..5], then `mac_source`[0..5], then `eth_type_length`[0..1].
- FSM states: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, DRAIN, FCS, IFG.
  - IDLE→PREAMBLE: on `start`; the header is registered in the same cycle.
  - PREAMBLE→SFD: after 7 accepted bytes of 0x55.
  - SFD→HEADER: after 1 accepted byte of 0xD5.
  - HEADER→PAYLOAD: after 14 accepted bytes.
  - PAYLOAD: `m_data`=`s_data`, `m_valid`=`s_valid`, `s_ready`=`m_ready` (combinational pass-through). A payload counter increments per accepted byte.
  - On accepted `s_last` with count<46: go to PAD.
  - On accepted `s_last` with count≥46: go to FCS.
  - On the accepted byte that brings count to `MAX_PAYLOAD` without `s_last`: go to DRAIN.
  - PAD: emits 0x00 until the payload count reaches 46, then goes to FCS.
  - DRAIN: `m_valid`=0 and `s_ready`=1; input bytes are discarded. On accepted `s_last`, pulse `trunc_err` and go to FCS.
  - FCS: emits 4 bytes, `m_last` on the 4th, then goes to IFG.
  - IFG: `m_valid`=0 for `IFG_CYCLES` cycles, then goes to IDLE.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers header, payload and pad bytes; excludes preamble and SFD.
  - The CRC updates only on accepted bytes.
  - FCS byte i = ~crc[8i+7:8i], sent i=0 first.
- Outside PAYLOAD and DRAIN, `s_ready`=0.
- `start` while `busy`=1 is ignored; there is no queuing.
- Every payload contains at least one byte; `s_last` terminates it.

## Timing
- Reset values: state=IDLE, crc=0xFFFFFFFF, all counters 0, header register 0.
- Outputs during reset: `busy`=0, `m_valid`=0, `m_last`=0, `s_ready`=0, `trunc_err`=0.
- Reset mid-frame aborts immediately: no FCS is emitted and the stream resumes at IDLE.
- Latency: first preamble byte has `m_valid`=1 in the cycle after `start` is accepted.
- Throughput: one byte per cycle when `m_ready`=1.
- Output-stream holding rule: `m_data`/`m_last` are held stable while `m_valid`&&!`m_ready`.
  - This holds in PAYLOAD too, provided upstream holds `s_data` (a standard valid/ready source).
- Frame length on the wire is 8+14+max(N,46)+4 bytes, with N capped at `MAX_PAYLOAD`.
- `busy` falls in the cycle the FSM returns to IDLE. A `start` in that same cycle is accepted.

## Structure
- `ethernet_header_pkg` gains the following shared items:
  - `PREAMBLE_BYTE`=8'h55, `SFD_BYTE`=8'hD5;
  - `MIN_PAYLOAD`=46, `HEADER_BYTES`=14;
  - `CRC32_POLY_REFL`, `CRC32_INIT`;
  - a typedef enum `eth_tx_state_t` for the FSM states.
- Sub-module `eth_crc32`, a byte-wide CRC register:
  - inputs `clk`, `rst_n`, `clear`, `en`, `data[7:0]`;
  - output `crc[31:0]`.
- `eth_frame_tx` instantiates `eth_crc32`. It drives `clear` in IDLE and `en` on accepted header, payload and pad bytes.

## Test plan
- `eth_crc32` alone: feed ASCII "123456789" after `clear`, then ~crc must equal 0xCBF43926.
- Payload of 10 bytes 0x01..0x0A, `m_ready`=1:
  - bytes 0..6 = 0x55, byte 7 = 0xD5, then header bytes in wire order;
  - 10 data bytes, then 36 zero pad bytes, then FCS matching the software model;
  - 72 bytes total, `m_last` on byte 72, `busy` low 12 cycles later.
- Payload of 100 bytes with random `m_ready` and `s_valid` gaps:
  - 126 bytes, content identical to the no-backpressure run;
  - no byte dropped or duplicated.
- `MAX_PAYLOAD`=64, payload of 80 bytes:
  - 64 bytes emitted and the remaining 16 drained;
  - `trunc_err` pulses once; FCS covers only the 64 bytes.
- `start` pulsed during HEADER is ignored. A `start` in the cycle `busy` falls begins a second frame next cycle.
- `rst_n` asserted mid-PAYLOAD: outputs reach reset values immediately; a new `start` then yields a correct full frame.

Source files
------------

// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet header type plus the constants, state type and CRC helpers
// used by the frame serializer and its CRC register.
package ethernet_header_pkg;

    typedef struct packed {
        logic [0:5][7:0] mac_destination;
        logic [0:5][7:0] mac_source;
        logic [0:1][7:0] eth_type_length;
    } ethernet_header;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          MIN_PAYLOAD     = 46;
    localparam int          HEADER_BYTES    = 14;
    localparam int          PREAMBLE_BYTES  = 7;
    localparam int          FCS_BYTES       = 4;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_SFD      = 4'd2,
        ST_HEADER   = 4'd3,
        ST_PAYLOAD  = 4'd4,
        ST_PAD      = 4'd5,
        ST_DRAIN    = 4'd6,
        ST_FCS      = 4'd7,
        ST_IFG      = 4'd8
    } eth_tx_state_t;

    // One byte of the reflected CRC-32, LSB of the data first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Header byte in wire order; the struct layout is already network order.
    function automatic logic [7:0] header_byte(input ethernet_header hdr, input logic [3:0] idx);
        logic [0:13][7:0] bytes;
        bytes = hdr;
        if (idx < 4'd14) begin
            return bytes[idx];
        end else begin
            return 8'h00;
        end
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 accumulator; clear has priority over en.
module eth_crc32
    import ethernet_header_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_r;

    // CRC state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= CRC32_INIT;
        end else if (clear) begin
            crc_r <= CRC32_INIT;
        end else if (en) begin
            crc_r <= crc32_byte(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame serializer: preamble/SFD, header, payload pass-through,
// zero pad, CRC-32 FCS and inter-frame gap on a valid/ready byte stream.
module eth_frame_tx
    import ethernet_header_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_CYCLES  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  ethernet_header header,
    output logic           busy,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [7:0]     m_data,
    output logic           m_valid,
    output logic           m_last,
    input  logic           m_ready,
    output logic           trunc_err
);

    localparam int PW = ($clog2(MAX_PAYLOAD + 1) > 7) ? $clog2(MAX_PAYLOAD + 1) : 7;
    localparam logic [PW-1:0] PAY_MAX  = PW'(MAX_PAYLOAD);
    localparam logic [PW-1:0] PAY_MIN  = PW'(MIN_PAYLOAD);
    localparam logic [15:0]   PRE_LAST = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0]   HDR_LAST = 16'(HEADER_BYTES - 1);
    localparam logic [15:0]   FCS_LAST = 16'(FCS_BYTES - 1);
    localparam logic [15:0]   IFG_LAST = 16'(IFG_CYCLES - 1);

    eth_tx_state_t   state_r;
    logic [15:0]     cnt_r;
    logic [PW-1:0]   pay_cnt_r;
    ethernet_header  hdr_r;
    logic            trunc_err_r;

    logic [7:0]      m_data_s;
    logic            m_valid_s;
    logic            m_last_s;
    logic            s_ready_s;
    logic            m_acc_s;
    logic            s_acc_s;
    logic            crc_en_s;
    logic [31:0]     crc_s;
    logic [PW-1:0]   pay_next_s;

    // Output stream and payload-ready decode from the current state
    always_comb begin
        m_data_s  = 8'h00;
        m_valid_s = 1'b0;
        m_last_s  = 1'b0;
        s_ready_s = 1'b0;
        case (state_r)
            ST_PREAMBLE: begin
                m_data_s  = PREAMBLE_BYTE;
                m_valid_s = 1'b1;
            end
            ST_SFD: begin
                m_data_s  = SFD_BYTE;
                m_valid_s = 1'b1;
            end
            ST_HEADER: begin
                m_data_s  = header_byte(hdr_r, cnt_r[3:0]);
                m_valid_s = 1'b1;
            end
            ST_PAYLOAD: begin
                m_data_s  = s_data;
                m_valid_s = s_valid;
                s_ready_s = m_ready;
            end
            ST_PAD: begin
                m_data_s  = 8'h00;
                m_valid_s = 1'b1;
            end
            ST_DRAIN: begin
                s_ready_s = 1'b1;
            end
            ST_FCS: begin
                m_data_s  = ~crc_s[{cnt_r[1:0], 3'b000} +: 8];
                m_valid_s = 1'b1;
                m_last_s  = (cnt_r == FCS_LAST);
            end
            default: begin
                m_data_s  = 8'h00;
                m_valid_s = 1'b0;
                m_last_s  = 1'b0;
                s_ready_s = 1'b0;
            end
        endcase
    end

    assign m_acc_s    = m_valid_s && m_ready;
    assign s_acc_s    = s_valid && s_ready_s;
    assign pay_next_s = pay_cnt_r + PW'(1);
    assign crc_en_s   = m_acc_s &&
                        ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD) || (state_r == ST_PAD));

    eth_crc32 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_r == ST_IDLE),
        .en    (crc_en_s),
        .data  (m_data_s),
        .crc   (crc_s)
    );

    // Frame sequencing FSM with its counters and the truncation pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            pay_cnt_r   <= '0;
            hdr_r       <= '0;
            trunc_err_r <= 1'b0;
        end else begin
            trunc_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= 16'd0;
                    pay_cnt_r <= '0;
                    if (start) begin
                        hdr_r   <= header;
                        state_r <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (m_acc_s) begin
                        if (cnt_r == PRE_LAST) begin
                            cnt_r   <= 16'd0;
                            state_r <= ST_SFD;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                end
                ST_SFD: begin
                    if (m_acc_s) begin
                        cnt_r   <= 16'd0;
                        state_r <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (m_acc_s) begin
                        if (cnt_r == HDR_LAST) begin
                            cnt_r   <= 16'd0;
                            state_r <= ST_PAYLOAD;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // s_last wins over the cap, so an exactly-MAX payload is not truncated
                    if (s_acc_s) begin
                        pay_cnt_r <= pay_next_s;
                        if (s_last) begin
                            cnt_r   <= 16'd0;
                            state_r <= (pay_next_s < PAY_MIN) ? ST_PAD : ST_FCS;
                        end else if (pay_next_s == PAY_MAX) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_PAD: begin
                    if (m_acc_s) begin
                        pay_cnt_r <= pay_next_s;
                        if (pay_next_s == PAY_MIN) begin
                            cnt_r   <= 16'd0;
                            state_r <= ST_FCS;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_acc_s && s_last) begin
                        trunc_err_r <= 1'b1;
                        cnt_r       <= 16'd0;
                        state_r     <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    if (m_acc_s) begin
                        if (cnt_r == FCS_LAST) begin
                            cnt_r   <= 16'd0;
                            state_r <= (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                end
                ST_IFG: begin
                    if (cnt_r == IFG_LAST) begin
                        cnt_r   <= 16'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    cnt_r   <= 16'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign m_data    = m_data_s;
    assign m_valid   = m_valid_s;
    assign m_last    = m_last_s;
    assign s_ready   = s_ready_s;
    assign trunc_err = trunc_err_r;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed, table-driven bench for eth_frame_tx (default and MAX_PAYLOAD=64
// instances) and a stand-alone eth_crc32 check.
module tb_eth_frame_tx;
    import ethernet_header_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, s_valid, s_last, m_ready, sel;
    logic [7:0] s_data;
    ethernet_header hdr;

    logic busy_d, s_ready_d, m_valid_d, m_last_d, trunc_d;
    logic busy_t, s_ready_t, m_valid_t, m_last_t, trunc_t;
    logic [7:0] m_data_d, m_data_t;
    logic crc_clear, crc_en;
    logic [7:0] crc_data;
    logic [31:0] crc_out;

    eth_frame_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start), .header(hdr), .busy(busy_d),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_d),
        .m_data(m_data_d), .m_valid(m_valid_d), .m_last(m_last_d), .m_ready(m_ready),
        .trunc_err(trunc_d)
    );

    eth_frame_tx #(.MAX_PAYLOAD(64), .IFG_CYCLES(12)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .header(hdr), .busy(busy_t),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_t),
        .m_data(m_data_t), .m_valid(m_valid_t), .m_last(m_last_t), .m_ready(m_ready),
        .trunc_err(trunc_t)
    );

    eth_crc32 u_crc (
        .clk(clk), .rst_n(rst_n), .clear(crc_clear), .en(crc_en), .data(crc_data), .crc(crc_out)
    );

    wire       busy_a    = sel ? busy_t    : busy_d;
    wire       s_ready_a = sel ? s_ready_t : s_ready_d;
    wire       m_valid_a = sel ? m_valid_t : m_valid_d;
    wire       m_last_a  = sel ? m_last_t  : m_last_d;
    wire       trunc_a   = sel ? trunc_t   : trunc_d;
    wire [7:0] m_data_a  = sel ? m_data_t  : m_data_d;

    int checks = 0;
    int failures = 0;

    logic [7:0] hdr_bytes [14] = '{8'h00, 8'h1B, 8'h21, 8'hAA, 8'hBB, 8'hCC,
                                   8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                   8'h08, 8'h00};
    logic [7:0] obuf [$];
    logic [7:0] expq [$];
    int ntrunc, last_cnt, last_idx, ifg_len, stray;

    typedef struct {
        int n;
        bit bp;
        bit trunc_dut;
        int exp_len;
        int exp_trunc;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Expected frame bytes with a bit-serial reference FCS
    task automatic build_expected(input int n, input int maxp);
        int k;
        logic [31:0] c;
        logic fb;
        expq.delete();
        for (int i = 0; i < 7; i++) expq.push_back(8'h55);
        expq.push_back(8'hD5);
        for (int i = 0; i < 14; i++) expq.push_back(hdr_bytes[i]);
        k = (n < maxp) ? n : maxp;
        for (int i = 0; i < k; i++) expq.push_back(8'(i + 1));
        for (int i = k; i < 46; i++) expq.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < expq.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ expq[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        c = ~c;
        expq.push_back(c[7:0]);
        expq.push_back(c[15:8]);
        expq.push_back(c[23:16]);
        expq.push_back(c[31:24]);
    endtask

    task automatic run_frame(input int n, input bit bp, input bit spur, input bit chain,
                             input bit skip_start, input int abort_at);
        int si;
        bit done, sacc;
        obuf.delete();
        ntrunc = 0; last_cnt = 0; last_idx = -1; ifg_len = 0; stray = 0;
        si = 0; done = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        if (!skip_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 0; k < 3000 && !done; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_mid_payload_outputs",
                    {27'd0, busy_a, m_valid_a, m_last_a, s_ready_a, trunc_a}, 32'd0);
                s_valid = 1'b0;
                return;
            end
            start = spur && (k == 10);
            m_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!s_valid && si < n) s_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data = 8'(si + 1);
            s_last = (si == n - 1);
            #1;
            if (trunc_a) ntrunc++;
            sacc = s_valid && s_ready_a;
            if (m_valid_a && m_ready) begin
                if (m_last_a) begin
                    last_cnt++;
                    last_idx = obuf.size();
                    done = 1'b1;
                end
                obuf.push_back(m_data_a);
            end
            step();
            if (sacc) begin
                si++;
                s_valid = 1'b0;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
        #1;
        while (busy_a && ifg_len < 100) begin
            ifg_len++;
            if (m_valid_a) stray++;
            if (trunc_a) ntrunc++;
            @(posedge clk);
            #2;
        end
        if (chain) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("chain_busy", {31'd0, busy_a}, 32'd1);
            chk("chain_first_valid", {31'd0, m_valid_a}, 32'd1);
            chk("chain_first_byte", {24'd0, m_data_a}, 32'h55);
        end
    endtask

    task automatic check_frame(input string tag, input int exp_len, input int exp_trunc);
        int bad;
        int lim;
        bad = -1;
        lim = (obuf.size() < expq.size()) ? obuf.size() : expq.size();
        for (int i = 0; i < lim; i++) begin
            if (obuf[i] !== expq[i] && bad < 0) bad = i;
        end
        chk({tag, "_model_len"}, expq.size(), exp_len);
        chk({tag, "_len"}, obuf.size(), exp_len);
        chk({tag, "_first_bad_byte"}, bad, -1);
        chk({tag, "_last_count"}, last_cnt, 1);
        chk({tag, "_last_pos"}, last_idx, exp_len - 1);
        chk({tag, "_ifg_busy"}, ifg_len, 12);
        chk({tag, "_ifg_valid"}, stray, 0);
        chk({tag, "_trunc"}, ntrunc, exp_trunc);
    endtask

    initial begin
        string s;
        vecs[0] = '{n:10,  bp:1'b0, trunc_dut:1'b0, exp_len:72, exp_trunc:0};
        vecs[1] = '{n:100, bp:1'b1, trunc_dut:1'b0, exp_len:126, exp_trunc:0};
        vecs[2] = '{n:100, bp:1'b0, trunc_dut:1'b0, exp_len:126, exp_trunc:0};
        vecs[3] = '{n:46,  bp:1'b0, trunc_dut:1'b0, exp_len:72, exp_trunc:0};
        vecs[4] = '{n:45,  bp:1'b1, trunc_dut:1'b0, exp_len:72, exp_trunc:0};
        vecs[5] = '{n:1,   bp:1'b0, trunc_dut:1'b0, exp_len:72, exp_trunc:0};
        vecs[6] = '{n:47,  bp:1'b0, trunc_dut:1'b0, exp_len:73, exp_trunc:0};
        vecs[7] = '{n:80,  bp:1'b0, trunc_dut:1'b1, exp_len:90, exp_trunc:1};
        vecs[8] = '{n:64,  bp:1'b0, trunc_dut:1'b1, exp_len:90, exp_trunc:0};
        vecs[9] = '{n:65,  bp:1'b1, trunc_dut:1'b1, exp_len:90, exp_trunc:1};

        hdr.mac_destination = 48'h001B21AABBCC;
        hdr.mac_source      = 48'h021122334455;
        hdr.eth_type_length = 16'h0800;
        sel = 1'b0; s_data = 8'h00; crc_clear = 1'b0; crc_en = 1'b0; crc_data = 8'h00;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        step();
        chk("reset_outputs_default", {27'd0, busy_d, m_valid_d, m_last_d, s_ready_d, trunc_d}, 32'd0);
        chk("reset_outputs_trunc_inst", {27'd0, busy_t, m_valid_t, m_last_t, s_ready_t, trunc_t}, 32'd0);
        chk("reset_crc", crc_out, 32'hFFFFFFFF);
        rst_n = 1'b1;
        step();

        s = "123456789";
        crc_clear = 1'b1;
        step();
        crc_clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            crc_en = 1'b1;
            crc_data = s[i];
            step();
        end
        crc_en = 1'b0;
        chk("crc32_check_value", ~crc_out, 32'hCBF43926);

        for (int i = 0; i < 10; i++) begin
            sel = vecs[i].trunc_dut;
            do_reset();
            build_expected(vecs[i].n, sel ? 64 : 1500);
            run_frame(vecs[i].n, vecs[i].bp, 1'b0, 1'b0, 1'b0, -1);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].exp_trunc);
        end

        // start during HEADER is ignored, start as busy falls chains a frame
        sel = 1'b0;
        do_reset();
        build_expected(20, 1500);
        run_frame(20, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        check_frame("spur_start", 72, 0);
        build_expected(12, 1500);
        run_frame(12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        check_frame("chained", 72, 0);

        // reset in the middle of the payload, then a clean frame
        do_reset();
        run_frame(60, 1'b0, 1'b0, 1'b0, 1'b0, 40);
        step();
        rst_n = 1'b1;
        step();
        build_expected(10, 1500);
        run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_frame("after_reset", 72, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
